sdrc_wb_responder: RTL
======================

# sdrc_wb_responder

Wishbone slave responder that answers the SDRAM-controller test bench's Wishbone initiator, acting as a cycle-accurate behavioural target for driver/monitor self-checks before the real controller is attached. It accepts classic and registered-feedback burst cycles, services them from an internal byte-maskable word memory with programmable wait states, and keeps beat counters for scoreboard cross-checks.

## Interface
- APP_AW, 26: Wishbone address width (byte address).
- dw, 32: data width; byte lanes = dw/8.
- MEM_AW, 10: memory word-address width; depth 2**MEM_AW words.
- WAIT_STATES, 2: idle cycles inserted before the first ack of each cycle; legal range 0..15.

Ports:
- wb_clk  in  1  clock; all logic on rising edge.
- wb_rst  in  1  synchronous, active-high reset.
- wb_cyc  in  1  bus cycle valid.
- wb_stb  in  1  strobe.
- wb_we  in  1  1 = write, 0 = read.
- wb_sel  in  dw/8  byte enables.
- wb_addr  in  APP_AW  byte address; word index = wb_addr[MEM_AW+1:2], upper bits ignored (aliasing).
- wb_dati  in  dw  write data from initiator.
- wb_cti  in  3  cycle type: 000 classic, 001 constant-address burst, 010 incrementing burst, 111 end of burst; others treated as 000.
- wb_ack  out  dw-independent 1  registered acknowledge.
- wb_dato  out  dw  registered read data.
- rd_beats  out  16  acked read beats, saturating.
- wr_beats  out  16  acked write beats, saturating.
- busy  out  1  high whenever state != IDLE.

## Operation
- Request = wb_cyc & wb_stb. States: IDLE, WAIT, ACK, BURST.
- IDLE: on request, latch word pointer ptr from wb_addr, latch we; go WAIT (counter loaded WAIT_STATES-1) or directly ACK if WAIT_STATES=0. For reads, wb_dato loaded from mem[ptr] on the edge entering ACK.
- WAIT: decrement counter; at 0 go ACK. Request dropped during WAIT -> IDLE, no ack, no write.
- ACK: wb_ack=1 for this cycle. At its closing edge, if request & we: mem[ptr] bytes with wb_sel=1 take wb_dati; counter increments.
  - wb_cti = 010 or 001 (and not 111): go BURST; ptr += 1 (010) or unchanged (001); read: wb_dato <= mem[next ptr].
  - otherwise: go IDLE, wb_ack=0.
- BURST: wb_ack held 1; one beat per cycle while request=1. Same write/pointer/read-prefetch rule each edge. Beat with wb_cti=111 is the last: ack drops next cycle, -> IDLE. Request deasserted in BURST -> ack 0, IDLE, beat not counted, no write.
- ptr wraps modulo 2**MEM_AW.
- wb_sel=0000 write: acked, counted, memory unchanged.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values: wb_ack 0, wb_dato 0, rd_beats 0, wr_beats 0, busy 0, state IDLE. Memory contents not reset.
- Reset mid-operation: next edge forces IDLE, ack 0; any beat coinciding with reset edge is neither written nor counted.
- Request sampled at edge n in IDLE -> wb_ack high in cycle after edge n+WAIT_STATES.
- Classic transfer: one ack cycle, then IDLE entered; IDLE never samples at the edge that closes ACK, so no double ack. Back-to-back classic cycles: WAIT_STATES+2 cycles per transfer.
- Burst: first beat at classic latency, then 1 beat/cycle, zero bubbles.
- Read data valid in every cycle wb_ack=1; write data sampled at edge ending each ack cycle.

## Structure
- Package sdrc_wb_pkg: CTI_CLASSIC, CTI_CONST, CTI_INCR, CTI_EOB constants; state enum resp_state_t; shared APP_AW/dw defaults.
- Sub-module sdrc_wb_resp_mem: single-port synchronous RAM, byte-write enables, registered read port.

## Test plan
- Reset: wb_rst high 2 cycles -> ack 0, dato 0, counters 0, busy 0.
- Classic write 0x0000_0010 <- 0xDEADBEEF sel 1111, then classic read -> ack after 2 wait cycles each, dato 0xDEADBEEF, wr_beats 1, rd_beats 1.
- Byte mask: write 0x11223344 sel 0101 over 0xDEADBEEF -> read 0xDE22BE44.
- Incrementing 4-beat write at 0x100 (cti 010,010,010,111) data 1..4, then 4-beat read -> 4 consecutive ack cycles each, data 1,2,3,4; counters 4/4 added.
- Wrap: incrementing read starting at word 1023 (MEM_AW=10) -> second beat returns word 0.
- Abort: drop wb_stb during WAIT and mid-burst; assert wb_rst mid-burst -> no further ack, no write, counters unchanged for dropped beat, busy 0 next cycle.

Source files
------------

// File: rtl/sdrc_wb_pkg.sv
// Shared definitions for the SDRAM-controller Wishbone responder:
// cycle-type codes, responder state encoding and bus-width defaults.
package sdrc_wb_pkg;

  localparam int APP_AW_DEF = 26;
  localparam int DW_DEF     = 32;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    RESP_IDLE  = 2'd0,
    RESP_WAIT  = 2'd1,
    RESP_ACK   = 2'd2,
    RESP_BURST = 2'd3
  } resp_state_t;

  // A beat carrying one of these cycle types keeps the burst open.
  // End-of-burst, classic and every reserved code close it.
  function automatic logic cti_continues(input logic [2:0] cti);
    return (cti == CTI_INCR) || (cti == CTI_CONST);
  endfunction

endpackage

// File: rtl/sdrc_wb_resp_mem.sv
// Single-port word memory with per-byte write enables and a registered,
// resettable read port. The array itself is never reset.
module sdrc_wb_resp_mem
  import sdrc_wb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            re,
  input  logic            we,
  input  logic [DW/8-1:0] sel,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem_r [0:(1<<AW)-1];
  logic [DW-1:0] rdata_r;

  // Byte-masked write: only lanes with sel set take new data.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (sel[b]) begin
          mem_r[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read register: cleared by reset, otherwise loaded only on request so it
  // holds the current beat's data for the whole ack cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= {DW{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/sdrc_wb_responder.sv
// Behavioural Wishbone target: classic and burst cycles served from an
// internal byte-maskable memory with a fixed number of wait states before
// the first ack, plus saturating read/write beat counters.
module sdrc_wb_responder
  import sdrc_wb_pkg::*;
#(
  parameter int APP_AW      = APP_AW_DEF,
  parameter int dw          = DW_DEF,
  parameter int MEM_AW      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [dw/8-1:0]   wb_sel,
  input  logic [APP_AW-1:0] wb_addr,
  input  logic [dw-1:0]     wb_dati,
  input  logic [2:0]        wb_cti,
  output logic              wb_ack,
  output logic [dw-1:0]     wb_dato,
  output logic [15:0]       rd_beats,
  output logic [15:0]       wr_beats,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE  = RESP_IDLE;
  localparam logic [1:0] ST_WAIT  = RESP_WAIT;
  localparam logic [1:0] ST_ACK   = RESP_ACK;
  localparam logic [1:0] ST_BURST = RESP_BURST;

  logic [1:0]        state_r;
  logic [1:0]        state_nx_s;
  logic [3:0]        cnt_r;
  logic [MEM_AW-1:0] ptr_r;
  logic              we_r;
  logic              ack_r;
  logic              busy_r;
  logic [15:0]       rd_beats_r;
  logic [15:0]       wr_beats_r;

  logic              req_s;
  logic              cont_s;
  logic              beat_s;
  logic [MEM_AW-1:0] word_s;
  logic [MEM_AW-1:0] next_ptr_s;
  logic              mem_we_s;
  logic              mem_re_s;
  logic [MEM_AW-1:0] mem_addr_s;
  logic              unused_addr_s;

  assign req_s      = wb_cyc & wb_stb;
  assign cont_s     = cti_continues(wb_cti);
  assign word_s     = wb_addr[MEM_AW+1:2];
  // Constant-address bursts keep the pointer; the increment wraps naturally.
  assign next_ptr_s = (wb_cti == CTI_INCR) ? (ptr_r + MEM_AW'(1)) : ptr_r;
  // A beat completes at the edge closing an ack cycle with the request held.
  assign beat_s     = req_s & ((state_r == ST_ACK) | (state_r == ST_BURST));
  // Upper address bits alias and the byte offset is irrelevant to word access.
  assign unused_addr_s = ^{wb_addr[APP_AW-1:MEM_AW+2], wb_addr[1:0]};

  // Next-state decision for the request/wait/ack sequencing.
  always_comb begin
    state_nx_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          if (WAIT_STATES == 0) begin
            state_nx_s = ST_ACK;
          end else begin
            state_nx_s = ST_WAIT;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!req_s) begin
          state_nx_s = ST_IDLE;
        end else if (cnt_r == 4'd0) begin
          state_nx_s = ST_ACK;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_ACK, ST_BURST: begin
        if (req_s && cont_s) begin
          state_nx_s = ST_BURST;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Memory port steering: reads are prefetched so data lands on the edge
  // that opens each ack cycle; writes land on the edge that closes it.
  always_comb begin
    mem_we_s   = 1'b0;
    mem_re_s   = 1'b0;
    mem_addr_s = ptr_r;
    if (wb_rst) begin
      mem_we_s   = 1'b0;
      mem_re_s   = 1'b0;
      mem_addr_s = ptr_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          mem_addr_s = word_s;
          mem_re_s   = req_s & ~wb_we & (WAIT_STATES == 0);
        end
        ST_WAIT: begin
          mem_addr_s = ptr_r;
          mem_re_s   = req_s & ~we_r & (cnt_r == 4'd0);
        end
        ST_ACK, ST_BURST: begin
          mem_we_s   = beat_s & we_r;
          mem_re_s   = beat_s & ~we_r & cont_s;
          mem_addr_s = we_r ? ptr_r : next_ptr_s;
        end
        default: begin
          mem_we_s   = 1'b0;
          mem_re_s   = 1'b0;
          mem_addr_s = ptr_r;
        end
      endcase
    end
  end

  // Control state, pointer, wait counter and registered ack/busy.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      ptr_r   <= {MEM_AW{1'b0}};
      we_r    <= 1'b0;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      ack_r   <= (state_nx_s == ST_ACK) || (state_nx_s == ST_BURST);
      busy_r  <= (state_nx_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (req_s) begin
            ptr_r <= word_s;
            we_r  <= wb_we;
            cnt_r <= 4'(WAIT_STATES - 1);
          end
        end
        ST_WAIT: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_ACK, ST_BURST: begin
          if (beat_s && cont_s) begin
            ptr_r <= next_ptr_s;
          end
        end
        default: begin
          cnt_r <= 4'd0;
        end
      endcase
    end
  end

  // Saturating beat counters, stepped once per completed beat.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      rd_beats_r <= 16'd0;
      wr_beats_r <= 16'd0;
    end else if (beat_s) begin
      if (we_r) begin
        if (wr_beats_r != 16'hFFFF) begin
          wr_beats_r <= wr_beats_r + 16'd1;
        end
      end else begin
        if (rd_beats_r != 16'hFFFF) begin
          rd_beats_r <= rd_beats_r + 16'd1;
        end
      end
    end
  end

  sdrc_wb_resp_mem #(
    .DW (dw),
    .AW (MEM_AW)
  ) u_mem (
    .clk   (wb_clk),
    .rst   (wb_rst),
    .re    (mem_re_s),
    .we    (mem_we_s),
    .sel   (wb_sel),
    .addr  (mem_addr_s),
    .wdata (wb_dati),
    .rdata (wb_dato)
  );

  assign wb_ack   = ack_r;
  assign busy     = busy_r;
  assign rd_beats = rd_beats_r;
  assign wr_beats = wr_beats_r;

endmodule
